// File: rtl/crc_data_send_pkg.sv
// Shared constants, ctrl-word field positions, FSM state type and CRC-32 helpers
// for the inline FCS generator.
package crc_data_send_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam int unsigned CTRL_LEN_MSB  = 16;
  localparam int unsigned CTRL_LEN_LSB  = 7;
  localparam int unsigned CTRL_PRIO_MSB = 6;
  localparam int unsigned CTRL_PRIO_LSB = 4;
  localparam int unsigned CTRL_DEST_MSB = 3;
  localparam int unsigned CTRL_DEST_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_DATA,
    ST_FCS,
    ST_WAIT_EOP
  } state_t;

  // Reflected CRC-32: byte goes into the low bits, then 8 LSB-first shifts.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h000000, b};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // FCS bytes in transmit order, first byte in the MSB lane.
  function automatic logic [31:0] fcs_word(input logic [31:0] crc);
    logic [31:0] f;
    f = ~crc;
    return {f[7:0], f[15:8], f[23:16], f[31:24]};
  endfunction

endpackage

// File: rtl/crc_data_send_crc32_word_upd.sv
// Combinational CRC-32 update over 1..4 bytes of a word; the first byte sits
// in lane nbytes-1 and later bytes follow in descending lanes.
module crc32_word_upd
  import crc_data_send_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] crc_out
);

  logic [31:0] w_crc;
  logic [1:0]  w_lane;

  always_comb begin
    w_crc  = crc_in;
    w_lane = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < 32'(nbytes)) begin
        w_lane = 2'(nbytes - 3'(k) - 3'd1);
        w_crc  = crc32_byte(w_crc, data[{w_lane, 3'b000} +: 8]);
      end
    end
    crc_out = w_crc;
  end

endmodule

// File: rtl/crc_data_send.sv
// Inline Ethernet FCS generator: forwards the write-packet stream with one cycle
// of latency and inserts a CRC-32 word after the last payload word.
module crc_data_send
  import crc_data_send_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned LENW = 11
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iWrSop,
  input  logic          iWrEop,
  input  logic          iWrVld,
  input  logic [DW-1:0] iWrData,
  output logic          oWrSop,
  output logic          oWrEop,
  output logic          oWrVld,
  output logic [DW-1:0] oWrData
);

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_crc;
  logic [LENW-1:0]   r_rem;
  logic [2:0]        w_nbytes;
  logic              w_last;
  logic [31:0]       w_crc_upd;
  logic              w_out_vld;
  logic [DW-1:0]     w_out_data;
  logic              r_sop;
  logic              r_eop;
  logic              r_vld;
  logic [DW-1:0]     r_data;

  assign w_nbytes = (r_rem >= LENW'(4)) ? 3'd4 : r_rem[2:0];
  assign w_last   = (r_rem <= LENW'(4));

  crc32_word_upd u_upd (
    .crc_in  (r_crc),
    .data    (iWrData),
    .nbytes  (w_nbytes),
    .crc_out (w_crc_upd)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Sop restarts from any state; an Eop before the count completes ends the packet without FCS.
  always_comb begin
    w_next = r_state;
    if (iWrSop) begin
      w_next = ST_CTRL;
    end else begin
      case (r_state)
        ST_IDLE:     w_next = ST_IDLE;
        ST_CTRL:     if (iWrEop) w_next = ST_IDLE;
                     else if (iWrVld) w_next = ST_DATA;
        ST_DATA:     if (iWrEop) w_next = ST_IDLE;
                     else if (iWrVld && w_last) w_next = ST_FCS;
        ST_FCS:      w_next = iWrEop ? ST_IDLE : ST_WAIT_EOP;
        ST_WAIT_EOP: if (iWrEop) w_next = ST_IDLE;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // The inserted FCS word takes the slot of any colliding input word.
  always_comb begin
    w_out_vld  = iWrVld;
    w_out_data = iWrData;
    if (r_state == ST_FCS && !iWrSop) begin
      w_out_vld  = 1'b1;
      w_out_data = fcs_word(r_crc);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_crc <= CRC32_INIT;
      r_rem <= '0;
    end else if (iWrSop) begin
      r_crc <= CRC32_INIT;
      r_rem <= '0;
    end else if (r_state == ST_CTRL && iWrVld && !iWrEop) begin
      r_crc <= CRC32_INIT;
      r_rem <= LENW'(iWrData[CTRL_LEN_MSB:CTRL_LEN_LSB]) + LENW'(1);
    end else if (r_state == ST_DATA && iWrVld && !iWrEop) begin
      r_crc <= w_crc_upd;
      r_rem <= r_rem - LENW'(w_nbytes);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_sop  <= iWrSop;
      r_eop  <= iWrEop;
      r_vld  <= w_out_vld;
      r_data <= w_out_vld ? w_out_data : '0;
    end
  end

  assign oWrSop  = r_sop;
  assign oWrEop  = r_eop;
  assign oWrVld  = r_vld;
  assign oWrData = r_data;

endmodule

// File: tb/tb_crc_data_send.sv
// Directed bench for crc_data_send: cycle vector table plus packet sequences
// checked against an independent bitwise CRC-32 model.
module tb_crc_data_send;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sop = 1'b0;
  logic        eop = 1'b0;
  logic        vld = 1'b0;
  logic [31:0] data = '0;
  logic        osop;
  logic        oeop;
  logic        ovld;
  logic [31:0] odata;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned vld_seen = 0;

  logic [7:0] pbytes [0:1023];

  always #5 clk = ~clk;

  crc_data_send #(.DW(32), .LENW(11)) dut (
    .iClk    (clk),
    .iRst    (rst),
    .iWrSop  (sop),
    .iWrEop  (eop),
    .iWrVld  (vld),
    .iWrData (data),
    .oWrSop  (osop),
    .oWrEop  (oeop),
    .oWrVld  (ovld),
    .oWrData (odata)
  );

  typedef struct {
    logic        isop;
    logic        ieop;
    logic        ivld;
    logic [31:0] idata;
    logic        esop;
    logic        eeop;
    logic        evld;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic is, input logic ie, input logic iv, input logic [31:0] id,
                              input logic es, input logic ee, input logic ev, input logic [31:0] ed);
    vec_t r;
    r.isop = is; r.ieop = ie; r.ivld = iv; r.idata = id;
    r.esop = es; r.eeop = ee; r.evld = ev; r.edata = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {sop,eop,vld,data}=%h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic v, input logic [31:0] d,
                      input logic es, input logic ee, input logic ev, input logic [31:0] ed,
                      input string name);
    sop = s; eop = e; vld = v; data = d;
    @(posedge clk);
    #1;
    if (ovld) vld_seen++;
    check(name, {osop, oeop, ovld, odata}, {es, ee, ev, ed});
  endtask

  function automatic logic [31:0] model_fcs_word(input int unsigned len);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int unsigned j = 0; j < len; j++) begin
      for (int unsigned i = 0; i < 8; i++) begin
        fb = c[0] ^ pbytes[j][i];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    return {c[7:0], c[15:8], c[23:16], c[31:24]};
  endfunction

  function automatic logic [31:0] pack_word(input int unsigned base, input int unsigned n);
    logic [31:0] w;
    w = '0;
    for (int unsigned k = 0; k < n; k++) begin
      w = w | (32'(pbytes[base + k]) << (8 * (n - 1 - k)));
    end
    return w;
  endfunction

  task automatic send_pkt(input int unsigned len, input int unsigned gap,
                          input int unsigned eop_gap, input string name);
    int unsigned nw;
    int unsigned n;
    logic [31:0] ctrl;
    logic [31:0] w;
    logic [31:0] f;
    nw = (len + 3) / 4;
    for (int unsigned j = 0; j < len; j++) pbytes[j] = 8'($urandom);
    ctrl = 32'(len - 1) << 7 | 32'h35;
    vld_seen = 0;
    step(1, 0, 0, '0, 1, 0, 0, '0, {name, " sop"});
    step(0, 0, 1, ctrl, 0, 0, 1, ctrl, {name, " ctrl"});
    for (int unsigned wi = 0; wi < nw; wi++) begin
      n = len - 4 * wi;
      if (n > 4) n = 4;
      w = pack_word(4 * wi, n);
      for (int unsigned g = 0; g < gap; g++) step(0, 0, 0, '0, 0, 0, 0, '0, {name, " gap"});
      step(0, 0, 1, w, 0, 0, 1, w, $sformatf("%s data%0d", name, wi));
    end
    f = model_fcs_word(len);
    if (eop_gap == 0) begin
      step(0, 1, 0, '0, 0, 1, 1, f, {name, " fcs+eop"});
    end else begin
      step(0, 0, 0, '0, 0, 0, 1, f, {name, " fcs"});
      for (int unsigned g = 1; g < eop_gap; g++) step(0, 0, 0, '0, 0, 0, 0, '0, {name, " wait"});
      step(0, 1, 0, '0, 0, 1, 0, '0, {name, " eop"});
    end
    check({name, " vld count"}, 35'(vld_seen), 35'(nw + 2));
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 1, 32'h00000400, 0, 0, 1, 32'h00000400);
    tbl[2]  = mk(0, 0, 1, 32'h31323334, 0, 0, 1, 32'h31323334);
    tbl[3]  = mk(0, 0, 1, 32'h35363738, 0, 0, 1, 32'h35363738);
    tbl[4]  = mk(0, 0, 1, 32'h00000039, 0, 0, 1, 32'h00000039);
    tbl[5]  = mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h2639F4CB);
    tbl[6]  = mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h0);
    tbl[7]  = mk(0, 0, 1, 32'h00000400, 0, 0, 1, 32'h00000400);
    tbl[8]  = mk(0, 0, 1, 32'h31323334, 0, 0, 1, 32'h31323334);
    tbl[9]  = mk(0, 0, 1, 32'h35363738, 0, 0, 1, 32'h35363738);
    tbl[10] = mk(0, 0, 1, 32'hFFFFFF39, 0, 0, 1, 32'hFFFFFF39);
    tbl[11] = mk(0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 32'h2639F4CB);
    tbl[12] = mk(0, 0, 1, 32'h11111111, 0, 0, 1, 32'h11111111);
    tbl[13] = mk(0, 1, 0, 32'h0,        0, 1, 0, 32'h0);
    tbl[14] = mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0);

    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset state", {osop, oeop, ovld, odata}, 35'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].isop, tbl[i].ieop, tbl[i].ivld, tbl[i].idata,
           tbl[i].esop, tbl[i].eeop, tbl[i].evld, tbl[i].edata, $sformatf("vec%0d", i));
    end

    send_pkt(64, 0, 0, "p64");
    send_pkt(128, 1, 1, "p128gap");
    send_pkt(65, 1, 0, "p65");
    send_pkt(66, 0, 2, "p66");
    send_pkt(67, 1, 1, "p67");
    send_pkt(20, 0, 0, "b2b_a");
    send_pkt(33, 0, 0, "b2b_b");
    send_pkt(1, 0, 0, "p1");
    send_pkt(1024, 0, 1, "p1024");

    // Reset in the middle of a payload.
    step(1, 0, 0, '0, 1, 0, 0, '0, "rst sop");
    step(0, 0, 1, 32'h00001F80, 0, 0, 1, 32'h00001F80, "rst ctrl");
    step(0, 0, 1, 32'hA5A5A5A5, 0, 0, 1, 32'hA5A5A5A5, "rst d0");
    step(0, 0, 1, 32'h5A5A5A5A, 0, 0, 1, 32'h5A5A5A5A, "rst d1");
    vld = 1'b1; data = 32'hCAFEF00D;
    rst = 1'b1;
    #1;
    check("rst async clear", {osop, oeop, ovld, odata}, 35'h0);
    @(posedge clk);
    #1;
    check("rst held", {osop, oeop, ovld, odata}, 35'h0);
    vld = 1'b0; data = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(40, 0, 0, "after rst");

    // Sop injected mid-payload: the aborted packet gets no FCS.
    step(1, 0, 0, '0, 1, 0, 0, '0, "abort sop");
    step(0, 0, 1, 32'h00001380, 0, 0, 1, 32'h00001380, "abort ctrl");
    step(0, 0, 1, 32'h01020304, 0, 0, 1, 32'h01020304, "abort d0");
    step(0, 0, 1, 32'h05060708, 0, 0, 1, 32'h05060708, "abort d1");
    step(0, 0, 1, 32'h090A0B0C, 0, 0, 1, 32'h090A0B0C, "abort d2");
    send_pkt(17, 0, 0, "post abort");

    // Early Eop: Eop forwarded, no FCS.
    step(1, 0, 0, '0, 1, 0, 0, '0, "early sop");
    step(0, 0, 1, 32'h00000980, 0, 0, 1, 32'h00000980, "early ctrl");
    step(0, 0, 1, 32'h11223344, 0, 0, 1, 32'h11223344, "early d0");
    step(0, 0, 1, 32'h55667788, 0, 0, 1, 32'h55667788, "early d1");
    step(0, 1, 0, '0, 0, 1, 0, '0, "early eop");
    step(0, 0, 0, '0, 0, 0, 0, '0, "early idle");
    send_pkt(9, 0, 0, "post early");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
